// File: rtl/median3x3_stream.sv
// Streaming 3x3 median filter: two line buffers, a 3x3 window and a two-stage sorting network.
// Optional centre-pixel bypass port is enabled by defining MEDIAN3X3_BYPASS_EN.
module median3x3_stream #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned IMG_W = 100,
    parameter int unsigned IMG_H = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_data,
    output logic             out_last,
    output logic             busy
`ifdef MEDIAN3X3_BYPASS_EN
    ,
    input  logic             bypass
`endif
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);

    typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

    state_t          state;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic            adv;
    logic            accept;
    logic            col_last;
    logic            row_last;
    logic            out_xfer_last;

    logic [PIX_W-1:0] lb1 [IMG_W];
    logic [PIX_W-1:0] lb2 [IMG_W];
    logic [PIX_W-1:0] win_top [3];
    logic [PIX_W-1:0] win_mid [3];
    logic [PIX_W-1:0] win_bot [3];

    logic             s0_valid;
    logic             s0_last;
    logic             s1_valid;
    logic             s1_last;
    logic [PIX_W-1:0] s1_lo  [3];
    logic [PIX_W-1:0] s1_md  [3];
    logic [PIX_W-1:0] s1_hi  [3];
    logic [PIX_W-1:0] s1_centre;
    logic [PIX_W-1:0] med_c;
`ifdef MEDIAN3X3_BYPASS_EN
    logic             s1_bypass;
`endif

    function automatic logic [PIX_W-1:0] min2(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [PIX_W-1:0] max2(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
        return (a < b) ? b : a;
    endfunction

    function automatic logic [PIX_W-1:0] min3(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b,
                                              input logic [PIX_W-1:0] c);
        return min2(min2(a, b), c);
    endfunction

    function automatic logic [PIX_W-1:0] max3(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b,
                                              input logic [PIX_W-1:0] c);
        return max2(max2(a, b), c);
    endfunction

    function automatic logic [PIX_W-1:0] med3(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b,
                                              input logic [PIX_W-1:0] c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    // Whole pipeline freezes while a valid output is not being taken.
    assign adv           = !out_valid || out_ready;
    assign in_ready      = rst_n && (state != FLUSH) && adv;
    assign accept        = in_valid && in_ready;
    assign col_last      = (col == CW'(IMG_W - 1));
    assign row_last      = (row == RW'(IMG_H - 1));
    assign out_xfer_last = out_valid && out_ready && out_last;

    // Line buffers shift one row down per column; window shifts left one column.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb2[col]   <= lb1[col];
            lb1[col]   <= in_data;
            win_top[0] <= win_top[1];
            win_top[1] <= win_top[2];
            win_top[2] <= lb2[col];
            win_mid[0] <= win_mid[1];
            win_mid[1] <= win_mid[2];
            win_mid[2] <= lb1[col];
            win_bot[0] <= win_bot[1];
            win_bot[1] <= win_bot[2];
            win_bot[2] <= in_data;
        end
    end

    // Raster counters, frame state and busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
            col   <= '0;
            row   <= '0;
            busy  <= 1'b0;
        end else begin
            if (accept) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
            case (state)
                FILL:    if (accept && row == RW'(1) && col_last) state <= RUN;
                RUN:     if (accept && row_last && col_last) state <= FLUSH;
                FLUSH:   if (out_xfer_last) state <= FILL;
                default: state <= FILL;
            endcase
            if (out_xfer_last)
                busy <= 1'b0;
            else if (accept && state == FILL && row == '0 && col == '0)
                busy <= 1'b1;
        end
    end

    // Stage valids and the registered output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid  <= 1'b0;
            s0_last   <= 1'b0;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (adv) begin
            s0_valid  <= accept && (row >= RW'(2)) && (col >= CW'(2));
            s0_last   <= accept && row_last && col_last;
            s1_valid  <= s0_valid;
            s1_last   <= s0_last;
            out_valid <= s1_valid;
            out_last  <= s1_valid && s1_last;
            if (s1_valid)
                out_data <= med_c;
        end
    end

    // Per-column sort into lo/mid/hi.
    always_ff @(posedge clk) begin
        if (adv && s0_valid) begin
            for (int i = 0; i < 3; i++) begin
                s1_lo[i] <= min3(win_top[i], win_mid[i], win_bot[i]);
                s1_md[i] <= med3(win_top[i], win_mid[i], win_bot[i]);
                s1_hi[i] <= max3(win_top[i], win_mid[i], win_bot[i]);
            end
            s1_centre <= win_mid[1];
`ifdef MEDIAN3X3_BYPASS_EN
            s1_bypass <= bypass;
`endif
        end
    end

    always_comb begin
        med_c = med3(max3(s1_lo[0], s1_lo[1], s1_lo[2]),
                     med3(s1_md[0], s1_md[1], s1_md[2]),
                     min3(s1_hi[0], s1_hi[1], s1_hi[2]));
`ifdef MEDIAN3X3_BYPASS_EN
        if (s1_bypass)
            med_c = s1_centre;
`endif
    end

`ifndef MEDIAN3X3_BYPASS_EN
    logic unused_centre;
    assign unused_centre = ^s1_centre;
`endif

endmodule

// File: tb/tb_median3x3_stream.sv
// Directed bench for median3x3_stream on a 5x4 image: ramp, impulse, stalls, back-to-back, reset.
module tb_median3x3_stream;

    localparam int unsigned PIX_W = 8;
    localparam int unsigned IMG_W = 5;
    localparam int unsigned IMG_H = 4;
    localparam int NPIX = 20;
    localparam int NOUT = 6;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [PIX_W-1:0] out_data;
    logic             out_last;
    logic             busy;
`ifdef MEDIAN3X3_BYPASS_EN
    logic             bypass = 1'b0;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] img  [NPIX];
    logic [7:0] expq [NOUT];
    logic [7:0] oq   [$];
    logic       lq   [$];
    int         tq   [$];
    int         accq [$];

    logic       prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;
    bit         tog_en = 1'b0;
    int         tog = 0;

    median3x3_stream #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
`ifdef MEDIAN3X3_BYPASS_EN
        , .bypass(bypass)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Output collector and stall rules, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && out_valid) begin
                chk("stall_data", out_data, prev_data);
                chk("stall_last", out_last, prev_last);
            end
            if (out_valid && !out_ready)
                chk("stall_in_ready", in_ready, 0);
            if (out_valid && out_ready) begin
                oq.push_back(out_data);
                lq.push_back(out_last);
                tq.push_back(cyc);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    // out_ready pattern 1,0,0,1 while enabled.
    always @(posedge clk) begin
        #1;
        if (tog_en) begin
            out_ready = (tog % 4 == 0) || (tog % 4 == 3);
            tog++;
        end
    end

    task automatic make_image(input int mode, input int base);
        for (int i = 0; i < NPIX; i++) begin
            if (mode == 0) img[i] = 8'(base + i);
            else           img[i] = 8'd10;
        end
        if (mode != 0) img[1*IMG_W + 1] = 8'd255;
        if (mode == 1) img[2*IMG_W + 3] = 8'd0;
    endtask

    function automatic logic [7:0] med9(input int r, input int c);
        logic [7:0] v [9];
        logic [7:0] t;
        int k = 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++) begin
                v[k] = img[(r + dr) * IMG_W + c + dc];
                k++;
            end
        for (int a = 0; a < 9; a++)
            for (int b = 0; b < 8 - a; b++)
                if (v[b] > v[b+1]) begin
                    t = v[b]; v[b] = v[b+1]; v[b+1] = t;
                end
        return v[4];
    endfunction

    task automatic make_exp(input bit centre_only);
        int k = 0;
        for (int r = 1; r <= IMG_H - 2; r++)
            for (int c = 1; c <= IMG_W - 2; c++) begin
                expq[k] = centre_only ? img[r*IMG_W + c] : med9(r, c);
                k++;
            end
    endtask

    task automatic clear_q();
        oq.delete(); lq.delete(); tq.delete(); accq.delete();
    endtask

    task automatic send_frame(input int npix);
        int i = 0;
        int guard = 0;
        while (i < npix && guard < 2000) begin
            in_valid = 1'b1;
            in_data  = img[i];
            @(negedge clk);
            if (in_ready) begin
                if ((i / IMG_W) >= 2 && (i % IMG_W) >= 2) accq.push_back(cyc + 1);
                i++;
            end
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        in_data  = '0;
        chk("send_done", i, npix);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while ((busy || out_valid) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_timeout"}, n < 200, 1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input bit lat);
        chk({tag, "_count"}, oq.size(), NOUT);
        for (int i = 0; i < NOUT && i < oq.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), oq[i], expq[i]);
            chk($sformatf("%s_last%0d", tag, i), lq[i], i == NOUT - 1);
            if (lat && i < accq.size())
                chk($sformatf("%s_lat%0d", tag, i), tq[i], accq[i] + 2);
        end
        clear_q();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit done;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        #2 rst_n  = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", in_ready, 1);
        @(posedge clk); #1;

        // Ramp: medians equal the centre values 6,7,8,11,12,13.
        make_image(0, 0); make_exp(1'b0); clear_q();
        chk("ramp_model0", expq[0], 6);
        send_frame(NPIX); wait_done("ramp"); check_outs("ramp", 1'b1);

        // Bright impulse and dark speck are both removed.
        make_image(1, 0); make_exp(1'b0); clear_q();
        send_frame(NPIX); wait_done("impulse"); check_outs("impulse", 1'b0);

        // Downstream stalls with a 1,0,0,1 ready pattern.
        make_image(0, 0); make_exp(1'b0); clear_q();
        tog = 0; tog_en = 1'b1;
        send_frame(NPIX); wait_done("toggle");
        tog_en = 1'b0;
        @(posedge clk); #3;
        out_ready = 1'b1;
        check_outs("toggle", 1'b0);

        // Back-to-back frames: input blocked during flush, busy drops between frames.
        make_image(0, 0); make_exp(1'b0); clear_q();
        send_frame(NPIX);
        in_valid = 1'b1; in_data = 8'hEE;
        n = 0; done = 1'b0;
        while (!done && n < 50) begin
            @(negedge clk);
            chk("flush_in_ready", in_ready, 0);
            if (out_valid && out_ready && out_last) done = 1'b1;
            n++;
        end
        chk("flush_end", done, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("busy_gap", busy, 0);
        check_outs("b2b_f1", 1'b0);
        make_image(0, 100); make_exp(1'b0);
        chk("b2b_model0", expq[0], 106);
        send_frame(NPIX); wait_done("b2b_f2"); check_outs("b2b_f2", 1'b0);

        // Reset after nine pixels discards the partial frame.
        make_image(0, 0); make_exp(1'b0); clear_q();
        send_frame(9);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("no_partial_out", oq.size(), 0);
        clear_q();
        send_frame(NPIX); wait_done("post_reset"); check_outs("post_reset", 1'b1);

`ifdef MEDIAN3X3_BYPASS_EN
        // Bypass passes the impulse through; without it the impulse is filtered.
        make_image(2, 0); make_exp(1'b1); clear_q();
        bypass = 1'b1;
        send_frame(NPIX); wait_done("bypass1"); check_outs("bypass1", 1'b0);
        bypass = 1'b0;
        make_exp(1'b0); clear_q();
        send_frame(NPIX); wait_done("bypass0"); check_outs("bypass0", 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
